// File: rtl/discrete_range_value_picker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : discrete_range_value_picker_pkg
// Brief    : Shared types, constants and helpers for the discrete range
//            value picker (FSM states, LFSR taps, cover-mask function).
// Revision : 1.0 - initial release
// ============================================================================
package discrete_range_value_picker_pkg;

    // Sequencer states, in the order a request walks through them
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PICK_CHOICE = 3'd1,
        ST_READ_TABLE  = 3'd2,
        ST_LATCH       = 3'd3,
        ST_PICK_VALUE  = 3'd4,
        ST_DONE        = 3'd5
    } picker_state_t;

    // Galois (right-shift) taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR16_TAPS = 16'hB400;

    // Smallest all-ones value (2^k - 1) that is >= the argument.
    // Smearing the top set bit downwards gives exactly that mask.
    function automatic logic [31:0] all_ones_mask(input logic [31:0] value);
        logic [31:0] mask;
        mask = value;
        for (int i = 0; i < 5; i++) begin
            mask = mask | (mask >> (1 << i));
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/discrete_range_value_picker_if.sv
`default_nettype none
// ============================================================================
// Module   : discrete_range_value_picker_if
// Brief    : Request, table-access and result signals of the picker.
//            slave = the picker itself, master = whoever drives requests and
//            models the table.
// Revision : 1.0 - initial release
// ============================================================================
interface discrete_range_value_picker_if #(
    parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = 8,
    parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 8,
    parameter int MAX_BIT_WIDTH_OF_DISCRETE_CHOICES = 4,
    parameter int LFSR_WIDTH                        = 16
);
    // request side
    logic                                          in_start;
    logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]   in_variable_index;
    logic [MAX_BIT_WIDTH_OF_DISCRETE_CHOICES-1:0]  in_last_choice_index;
    logic                                          in_seed_load;
    logic [LFSR_WIDTH-1:0]                         in_seed;
    // table side
    logic                                          out_table_enable;
    logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]   out_variable_index;
    logic [MAX_BIT_WIDTH_OF_DISCRETE_CHOICES-1:0]  out_index_of_the_discrete_value;
    logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]  in_table_start;
    logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]  in_table_end;
    // result side
    logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]  out_value;
    logic                                          out_valid;
    logic                                          out_range_error;
    logic                                          out_busy;

    modport slave (
        input  in_start, in_variable_index, in_last_choice_index,
               in_seed_load, in_seed, in_table_start, in_table_end,
        output out_table_enable, out_variable_index,
               out_index_of_the_discrete_value, out_value, out_valid,
               out_range_error, out_busy
    );

    modport master (
        output in_start, in_variable_index, in_last_choice_index,
               in_seed_load, in_seed, in_table_start, in_table_end,
        input  out_table_enable, out_variable_index,
               out_index_of_the_discrete_value, out_value, out_valid,
               out_range_error, out_busy
    );
endinterface
`default_nettype wire

// File: rtl/discrete_range_value_picker_galois_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : discrete_range_value_picker_galois_lfsr
// Brief    : Free-running right-shift Galois LFSR with seed load. A zero seed
//            would lock the register, so it is replaced by the reset seed.
// Revision : 1.0 - initial release
// ============================================================================
module discrete_range_value_picker_galois_lfsr #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] seed,
    output logic      [WIDTH-1:0] state
);

    logic [WIDTH-1:0] r_state;

    // Step every cycle; a load replaces the step for that cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (load) begin
            r_state <= (seed == '0) ? SEED : seed;
        end else begin
            r_state <= {1'b0, r_state[WIDTH-1:1]} ^ (r_state[0] ? TAPS : '0);
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/discrete_range_value_picker.sv
`default_nettype none
// ============================================================================
// Module   : discrete_range_value_picker
// Brief    : Picks a random choice index for a variable, reads its {start,end}
//            range from the discrete values table and draws a uniform value
//            in that range by masked rejection sampling with a bounded
//            number of retries.
// Revision : 1.0 - initial release
// ============================================================================
module discrete_range_value_picker
    import discrete_range_value_picker_pkg::*;
#(
    parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = 8,
    parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 8,
    parameter int MAX_BIT_WIDTH_OF_DISCRETE_CHOICES = 4,
    parameter int LFSR_WIDTH                        = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED      = LFSR_WIDTH'(16'hACE1),
    parameter int REJECT_LIMIT                      = 7
) (
    input  wire logic                      in_clock,
    input  wire logic                      in_reset,
    discrete_range_value_picker_if.slave   picker
);

    localparam int IW      = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
    localparam int VW      = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
    localparam int CW      = MAX_BIT_WIDTH_OF_DISCRETE_CHOICES;
    localparam int RETRY_W = (REJECT_LIMIT < 1) ? 1 : $clog2(REJECT_LIMIT + 1);

    picker_state_t        state_q, state_d;
    logic [LFSR_WIDTH-1:0] lfsr_state;
    logic                 lfsr_load;

    logic [VW-1:0]        variable_index_q;
    logic [CW-1:0]        last_choice_q;
    logic [CW-1:0]        choice_q;
    logic [RETRY_W-1:0]   retry_q;
    logic [IW-1:0]        range_start_q;
    logic [IW-1:0]        span_q;
    logic [IW-1:0]        value_mask_q;
    logic                 range_error_q;
    logic [IW-1:0]        value_q;

    logic [CW-1:0]        choice_mask;
    logic [CW-1:0]        choice_candidate;
    logic [CW-1:0]        choice_pick;
    logic                 choice_accept;
    logic [IW-1:0]        offset_candidate;
    logic [IW-1:0]        offset_pick;
    logic                 offset_accept;
    logic                 retry_exhausted;
    logic                 range_inverted;
    logic [IW-1:0]        span_next;

    logic                 table_enable;
    logic                 valid;
    logic                 range_error;
    logic                 busy;

    // Only the low bits of the LFSR feed the draws; the rest just keep the
    // sequence long.
    logic                 unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr_state;

    // A seed load only lands while idle and never in the cycle a request starts
    assign lfsr_load = (state_q == ST_IDLE) && picker.in_seed_load && !picker.in_start;

    discrete_range_value_picker_galois_lfsr #(
        .WIDTH (LFSR_WIDTH),
        .TAPS  (LFSR_WIDTH'(LFSR16_TAPS)),
        .SEED  (LFSR_SEED)
    ) u_galois_lfsr (
        .clk   (in_clock),
        .rst   (in_reset),
        .load  (lfsr_load),
        .seed  (picker.in_seed),
        .state (lfsr_state)
    );

    // Rejection-sampling candidates; on the final retry the halved candidate
    // is always inside the bound, since mask >> 1 < bound.
    always_comb begin
        retry_exhausted  = (retry_q == RETRY_W'(REJECT_LIMIT));
        choice_mask      = CW'(all_ones_mask(32'(last_choice_q)));
        choice_candidate = lfsr_state[CW-1:0] & choice_mask;
        choice_accept    = (choice_candidate <= last_choice_q) || retry_exhausted;
        choice_pick      = (choice_candidate <= last_choice_q) ? choice_candidate
                                                               : (choice_candidate >> 1);
        offset_candidate = lfsr_state[IW-1:0] & value_mask_q;
        offset_accept    = (offset_candidate <= span_q) || retry_exhausted;
        offset_pick      = (offset_candidate <= span_q) ? offset_candidate
                                                        : (offset_candidate >> 1);
        range_inverted   = (picker.in_table_end < picker.in_table_start);
        span_next        = range_inverted ? '0 : (picker.in_table_end - picker.in_table_start);
    end

    // State register
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_d      = state_q;
        table_enable = 1'b0;
        valid        = 1'b0;
        range_error  = 1'b0;
        busy         = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE:        if (picker.in_start) state_d = ST_PICK_CHOICE;
            ST_PICK_CHOICE: if (choice_accept)   state_d = ST_READ_TABLE;
            ST_READ_TABLE: begin
                table_enable = 1'b1;
                state_d      = ST_LATCH;
            end
            ST_LATCH:       state_d = ST_PICK_VALUE;
            ST_PICK_VALUE:  if (offset_accept)   state_d = ST_DONE;
            ST_DONE: begin
                valid       = 1'b1;
                range_error = range_error_q;
                state_d     = ST_IDLE;
            end
            default:        state_d = ST_IDLE;
        endcase
    end

    // Request capture, choice/value selection and range latching
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            variable_index_q <= '0;
            last_choice_q    <= '0;
            choice_q         <= '0;
            retry_q          <= '0;
            range_start_q    <= '0;
            span_q           <= '0;
            value_mask_q     <= '0;
            range_error_q    <= 1'b0;
            value_q          <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (picker.in_start) begin
                        variable_index_q <= picker.in_variable_index;
                        last_choice_q    <= picker.in_last_choice_index;
                    end
                end
                ST_PICK_CHOICE: begin
                    if (choice_accept) begin
                        choice_q <= choice_pick;
                        retry_q  <= '0;
                    end else begin
                        retry_q  <= retry_q + 1'b1;
                    end
                end
                ST_LATCH: begin
                    range_start_q <= picker.in_table_start;
                    span_q        <= span_next;
                    value_mask_q  <= IW'(all_ones_mask(32'(span_next)));
                    range_error_q <= range_inverted;
                end
                ST_PICK_VALUE: begin
                    if (offset_accept) begin
                        value_q <= range_start_q + offset_pick;
                        retry_q <= '0;
                    end else begin
                        retry_q <= retry_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign picker.out_table_enable                = table_enable;
    assign picker.out_variable_index              = variable_index_q;
    assign picker.out_index_of_the_discrete_value = choice_q;
    assign picker.out_value                       = value_q;
    assign picker.out_valid                       = valid;
    assign picker.out_range_error                 = range_error;
    assign picker.out_busy                        = busy;

endmodule
`default_nettype wire

// File: doc/discrete_range_value_picker.md
Name: discrete_range_value_picker

Overview:
- Sequencer directly upstream and downstream of the discrete values table (registered RAM of {start,end} ranges indexed by {variable index, choice index}).
- On request, picks a random choice index for a variable and drives the table address and enable.
- Captures the returned range one cycle later and draws a uniform random value within it.
- Produces one random value per request for the inside-constraint path of the probabilistic search.

Parameters:
- MAX_BIT_WIDTH_OF_INTEGER_VARIABLE, 8, width of range bounds and output value
- MAX_BIT_WIDTH_OF_VARIABLES_INDEX, 8, width of variable index
- MAX_BIT_WIDTH_OF_DISCRETE_CHOICES, 4, width of choice index (up to 16 choices)
- LFSR_WIDTH, 16, internal Galois LFSR width; must be >= integer and choice widths
- LFSR_SEED, 16'hACE1, reset seed; must be nonzero
- REJECT_LIMIT, 7, rejection retries before deterministic fallback

Ports:
- in_clock  in  1  clock; all logic on the rising edge
- in_reset  in  1  synchronous, active-high reset
- in_start  in  1  request pulse; accepted only in IDLE
- in_variable_index  in  MAX_BIT_WIDTH_OF_VARIABLES_INDEX  variable to draw for
- in_last_choice_index  in  MAX_BIT_WIDTH_OF_DISCRETE_CHOICES  number of valid choices minus 1
- in_seed_load  in  1  load in_seed into the LFSR; ignored unless IDLE
- in_seed  in  LFSR_WIDTH  seed value; zero is replaced by LFSR_SEED
- out_table_enable  out  1  enable to the table
- out_variable_index  out  MAX_BIT_WIDTH_OF_VARIABLES_INDEX  table address, high part
- out_index_of_the_discrete_value  out  MAX_BIT_WIDTH_OF_DISCRETE_CHOICES  table address, low part
- in_table_start  in  MAX_BIT_WIDTH_OF_INTEGER_VARIABLE  range start from the table
- in_table_end  in  MAX_BIT_WIDTH_OF_INTEGER_VARIABLE  range end from the table
- out_value  out  MAX_BIT_WIDTH_OF_INTEGER_VARIABLE  drawn value; held until the next completion
- out_valid  out  1  one-cycle pulse; out_value is new
- out_range_error  out  1  one-cycle pulse with out_valid when end < start
- out_busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE, LFSR = LFSR_SEED, all outputs 0, retry counter 0.
- LFSR steps every cycle, including while IDLE. Only a seed load overrides the step.
- States: IDLE -> PICK_CHOICE -> READ_TABLE -> LATCH -> PICK_VALUE -> DONE -> IDLE.
- IDLE:
  - in_start registers the variable index and last choice index, then moves to PICK_CHOICE.
  - in_start has priority over in_seed_load in the same cycle.
  - in_start outside IDLE is ignored (no queueing).
- PICK_CHOICE:
  - choice_mask = smallest 2^k-1 >= last choice index.
  - Candidate = LFSR low bits & choice_mask.
  - If candidate <= last, register it as the choice index and go to READ_TABLE. Otherwise increment the retry counter and stay.
  - When the retry counter reaches REJECT_LIMIT, use candidate>>1 instead; it is always in range.
  - Retry counter clears on leaving the state.
- READ_TABLE: out_table_enable = 1 for exactly this cycle. Address outputs are stable from here until DONE.
- LATCH:
  - Capture in_table_start and in_table_end (the table output registered at the end of READ_TABLE).
  - span = end - start.
  - If end < start: set the error flag, force span = 0.
  - value_mask = smallest 2^k-1 >= span.
- PICK_VALUE:
  - offset = LFSR low bits & value_mask.
  - Accept if offset <= span; else retry, with the same REJECT_LIMIT and >>1 fallback as PICK_CHOICE.
  - out_value <= start + offset. No overflow is possible, since start + span = end.
- DONE: out_valid = 1 (with out_range_error if flagged) for one cycle, then IDLE.
- Minimum latency: in_start at cycle 0 -> out_valid at cycle 5. Worst case adds 2*REJECT_LIMIT cycles.
- Back-to-back: the next in_start is accepted in the cycle after DONE.
- Reset mid-operation: immediate return to IDLE, outputs cleared, no out_valid emitted.

Decomposition:
- Shared package:
  - state enum
  - function returning the smallest all-ones mask covering a value
  - LFSR tap constant for LFSR_WIDTH 16 (polynomial x^16+x^14+x^13+x^11+1)
- Sub-module galois_lfsr:
  - ports: clock, reset, load, seed, state output
  - zero-seed guard inside

Test Plan:
- Degenerate range: reset, last choice 0, table model returns (42,42) → enable pulses at cycle 2, out_table_enable address {var,0}, out_value = 42, out_valid exactly at cycle 5, no error.
- Inverted range: table returns start 10, end 5 → out_value = 10, out_range_error and out_valid pulse together.
- Full range: table returns (0,255), seed 16'h0001, 1000 draws → every value 0..255 reachable; no draw exceeds 5 cycles latency (mask 0xFF never rejects).
- Choice bound: last choice 4 over 2000 draws → choice index never > 4, all of 0..4 seen; every draw completes within 5 + 2*7 cycles.
- Protocol: in_start during busy is ignored; in_seed_load with 0 yields LFSR_SEED; identical seed gives an identical value sequence.
- Reset mid-op: assert in_reset during PICK_VALUE → next cycle out_busy = 0, out_value = 0, no out_valid; a fresh request then completes normally.
